// File: rtl/fp_pkg.sv
// Shared floating-point constants: default field widths, exponent helpers and
// bit offsets of the packed {sign, exp, mantissa} result word.
package fp_pkg;

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int HP_EXP_W = 5;
    localparam int HP_MAN_W = 10;

    localparam int SP_MAN_LSB  = 0;
    localparam int SP_EXP_LSB  = SP_MAN_W;
    localparam int SP_SIGN_POS = SP_EXP_W + SP_MAN_W;
    localparam int HP_MAN_LSB  = 0;
    localparam int HP_EXP_LSB  = HP_MAN_W;
    localparam int HP_SIGN_POS = HP_EXP_W + HP_MAN_W;

    // Low w bits set; callers cast down to their exponent width.
    function automatic logic [31:0] exp_all_ones(input int w);
        if (w >= 32) return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int exp_lsb(input int man_w);
        return man_w;
    endfunction

    function automatic int sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_normalize_pipe_if.sv
// Operand/result stream bundle for the normalizer; the master drives operands
// and result acceptance, the slave (normalizer) drives readiness and results.
interface fp_normalize_pipe_if #(
    parameter int EXP_W = fp_pkg::SP_EXP_W,
    parameter int MAN_W = fp_pkg::SP_MAN_W
);
    localparam int DW = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W:0]   in_sig;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_zero;
    logic             out_denorm;
    logic             out_special;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_denorm, out_special
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_denorm, out_special
    );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter over W bits built from 4-bit groups; the most significant
// non-zero group wins. An all-zero input returns W.
module fp_lzc #(
    parameter  int W  = 24,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt
);
    localparam int NG = (W + 3) / 4;
    localparam int PW = NG * 4;

    function automatic logic [1:0] nib_lz(input logic [3:0] n);
        casez (n)
            4'b1???: return 2'd0;
            4'b01??: return 2'd1;
            4'b001?: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [PW-1:0] pad_vec;

    // Padding ones below the LSB make an all-zero input count exactly W.
    always_comb begin
        pad_vec = '1;
        pad_vec[PW-1 -: W] = vec;
    end

    always_comb begin
        cnt = CW'(W);
        for (int g = 0; g < NG; g++) begin
            if (pad_vec[4*g +: 4] != 4'b0000)
                cnt = CW'((NG - 1 - g) * 4 + int'(nib_lz(pad_vec[4*g +: 4])));
        end
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage floating-point normalizer: S1 counts leading zeros, S2 shifts, adjusts
// the exponent and classifies. Latency 2, one result per cycle, stalls on out_ready.
module fp_normalize_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = SP_EXP_W,
    parameter  int MAN_W = SP_MAN_W,
    localparam int SH_W  = $clog2(MAN_W + 2)
) (
    input  logic              clk,
    input  logic              rst,
    fp_normalize_pipe_if.slave bus
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int XW = (EXP_W + 1 > SH_W) ? EXP_W + 1 : SH_W;
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));

    logic             s1_adv;
    logic             s2_adv;
    logic             s1_valid;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W:0]   s1_sig;
    logic [SH_W-1:0]  s1_lzc;
    logic [SH_W-1:0]  lzc;

    logic             s2_valid;
    logic [DW-1:0]    s2_data;
    logic             s2_zero;
    logic             s2_denorm;
    logic             s2_special;

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;

    fp_lzc #(.W(MAN_W + 1)) u_lzc (
        .vec (bus.in_sig),
        .cnt (lzc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_lzc   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= bus.in_sign;
                s1_exp  <= bus.in_exp;
                s1_sig  <= bus.in_sig;
                s1_lzc  <= lzc;
            end
        end
    end

    logic [XW-1:0]    e_eff;
    logic [XW-1:0]    lzc_x;
    logic [SH_W-1:0]  shamt;
    logic [EXP_W-1:0] exp_n;
    logic [MAN_W-1:0] man_n;
    logic             zero_n;
    logic             denorm_n;
    logic             special_n;

    // A zero exponent field is treated as 1 so denormal inputs line up with the smallest normal.
    always_comb begin
        e_eff     = (s1_exp == '0) ? XW'(1) : XW'(s1_exp);
        lzc_x     = XW'(s1_lzc);
        shamt     = '0;
        exp_n     = '0;
        man_n     = '0;
        zero_n    = 1'b0;
        denorm_n  = 1'b0;
        special_n = 1'b0;
        if (s1_exp == EXP_ONES) begin
            special_n = 1'b1;
            exp_n     = EXP_ONES;
            man_n     = s1_sig[MAN_W-1:0];
        end else if (s1_sig == '0) begin
            zero_n = 1'b1;
        end else if (e_eff > lzc_x) begin
            shamt = s1_lzc;
            exp_n = EXP_W'(e_eff - lzc_x);
            man_n = MAN_W'(s1_sig << shamt);
        end else begin
            denorm_n = 1'b1;
            shamt    = SH_W'(e_eff - XW'(1));
            man_n    = MAN_W'(s1_sig << shamt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_zero    <= 1'b0;
            s2_denorm  <= 1'b0;
            s2_special <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data    <= {s1_sign, exp_n, man_n};
                s2_zero    <= zero_n;
                s2_denorm  <= denorm_n;
                s2_special <= special_n;
            end
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_data    = s2_data;
    assign bus.out_zero    = s2_zero;
    assign bus.out_denorm  = s2_denorm;
    assign bus.out_special = s2_special;

endmodule
